led_activity_monitor: RTL

LED_ACTIVITY_MONITOR -- requirements
Module: led_activity_monitor

---
 rtl/led_activity_monitor.sv | 121 ++++++++++++
 1 files changed

// File: rtl/led_activity_monitor.sv
// Activity monitor for a small CPU core: decodes executed instructions into five
// channels and shows sticky flags, stretched pulses, live debug or ALU result on LEDs.
module led_activity_monitor #(
    parameter int N_LEDS      = 8,
    parameter int HB_DIV      = 25000000,
    parameter int STRETCH_CYC = 4000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       Instr,
    input  logic [2:0]        ALUControl,
    input  logic [31:0]       ALUResult,
    input  logic              RegWrite,
    input  logic [1:0]        mode,
    input  logic              clear_flags,
    output logic [N_LEDS-1:0] LED
);

    localparam int N_CH = 5;
    localparam int CW   = $clog2(STRETCH_CYC + 1);
    localparam int HW   = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;

    localparam logic [CW-1:0] STRETCH_LOAD = CW'(STRETCH_CYC);
    localparam logic [HW-1:0] HB_LAST      = HW'(HB_DIV - 1);

    logic [N_CH-1:0]   ev;
    logic [N_CH-1:0]   flags_q;
    logic [N_CH-1:0]   pulse;
    logic [CW-1:0]     stretch_cnt [N_CH];
    logic [HW-1:0]     hb_cnt;
    logic              hb_q;
    logic [N_LEDS-2:0] result_q;
    logic [1:0]        mode_q;
    logic [N_LEDS-1:0] led_d;
    logic              unused_bits;

    assign unused_bits = ^{Instr[31:28], Instr[25], Instr[20:0], ALUResult[31:N_LEDS-1]};

    // MOV (data-processing, opcode 1101) overrides the ALU-op channels.
    always_comb begin
        ev = '0;
        if (RegWrite) begin
            if (Instr[27:26] == 2'b00 && Instr[24:21] == 4'b1101) begin
                ev[3] = 1'b1;
            end else begin
                case (ALUControl)
                    3'b000:  ev[0] = 1'b1;
                    3'b001:  ev[1] = 1'b1;
                    3'b100:  ev[2] = 1'b1;
                    default: ev[4] = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= '0;
        end else if (clear_flags) begin
            flags_q <= ev;
        end else begin
            flags_q <= flags_q | ev;
        end
    end

    // A re-fire reloads rather than accumulates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CH; i++) stretch_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (ev[i]) begin
                    stretch_cnt[i] <= STRETCH_LOAD;
                end else if (stretch_cnt[i] != '0) begin
                    stretch_cnt[i] <= stretch_cnt[i] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) pulse[i] = (stretch_cnt[i] != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hb_cnt <= '0;
            hb_q   <= 1'b0;
        end else if (hb_cnt == HB_LAST) begin
            hb_cnt <= '0;
            hb_q   <= ~hb_q;
        end else begin
            hb_cnt <= hb_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= '0;
            mode_q   <= 2'b00;
        end else begin
            mode_q <= mode;
            if (RegWrite) result_q <= ALUResult[N_LEDS-2:0];
        end
    end

    // Debug mode is the only view that passes inputs straight through.
    always_comb begin
        led_d = '0;
        case (mode_q)
            2'b00:   led_d[4:0] = flags_q;
            2'b01:   led_d[4:0] = pulse;
            2'b10:   led_d[4:0] = {(Instr[27:26] == 2'b00), ALUControl, RegWrite};
            default: led_d[N_LEDS-2:0] = result_q;
        endcase
        led_d[N_LEDS-1] = hb_q;
    end

    assign LED = led_d;

endmodule
